bus_transfer_decoder: RTL and testbench

//  Drive side of the shared 32-bit datapath bus. Queues register-transfer commands
//  (5-bit source code, 5-bit destination code) and decodes each one into one-hot

---
 rtl/bus_codes_pkg.sv | 67 ++++++
 rtl/cmd_fifo.sv | 55 +++++
 rtl/bus_transfer_decoder.sv | 120 ++++++++++++
 tb/tb_bus_transfer_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_codes_pkg.sv
// Shared codes, widths and helpers for the datapath bus transfer decoder.
package bus_codes_pkg;

  localparam int CODE_W = 5;
  localparam int NSRC   = 24;
  localparam int NDST   = 24;
  localparam int CMD_W  = 2 * CODE_W;

  // Bus source codes (0..15 are R0..R15)
  localparam logic [CODE_W-1:0] SRC_R0     = 5'd0;
  localparam logic [CODE_W-1:0] SRC_R15    = 5'd15;
  localparam logic [CODE_W-1:0] SRC_HI     = 5'd16;
  localparam logic [CODE_W-1:0] SRC_LO     = 5'd17;
  localparam logic [CODE_W-1:0] SRC_ZHI    = 5'd18;
  localparam logic [CODE_W-1:0] SRC_ZLO    = 5'd19;
  localparam logic [CODE_W-1:0] SRC_PC     = 5'd20;
  localparam logic [CODE_W-1:0] SRC_MDR    = 5'd21;
  localparam logic [CODE_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [CODE_W-1:0] SRC_CSIGN  = 5'd23;

  // Register load destination codes (0..15 are R0..R15)
  localparam logic [CODE_W-1:0] DST_R0      = 5'd0;
  localparam logic [CODE_W-1:0] DST_R15     = 5'd15;
  localparam logic [CODE_W-1:0] DST_HI      = 5'd16;
  localparam logic [CODE_W-1:0] DST_LO      = 5'd17;
  localparam logic [CODE_W-1:0] DST_PC      = 5'd18;
  localparam logic [CODE_W-1:0] DST_MDR     = 5'd19;
  localparam logic [CODE_W-1:0] DST_MAR     = 5'd20;
  localparam logic [CODE_W-1:0] DST_OUTPORT = 5'd21;
  localparam logic [CODE_W-1:0] DST_Y       = 5'd22;
  localparam logic [CODE_W-1:0] DST_IR      = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2
  } xferState_t;

  typedef struct packed {
    logic [CODE_W-1:0] src;
    logic [CODE_W-1:0] dst;
  } xferCmd_t;

  function automatic logic srcValid(input logic [CODE_W-1:0] code);
    return code < CODE_W'(NSRC);
  endfunction

  function automatic logic dstValid(input logic [CODE_W-1:0] code);
    return code < CODE_W'(NDST);
  endfunction

  // Out-of-range codes decode to all zeros so they can never raise a strobe.
  function automatic logic [NSRC-1:0] decodeSrc(input logic [CODE_W-1:0] code);
    logic [NSRC-1:0] oneHot;
    oneHot = '0;
    if (srcValid(code)) oneHot = NSRC'(1) << code;
    return oneHot;
  endfunction

  function automatic logic [NDST-1:0] decodeDst(input logic [CODE_W-1:0] code);
    logic [NDST-1:0] oneHot;
    oneHot = '0;
    if (dstValid(code)) oneHot = NDST'(1) << code;
    return oneHot;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue in front of the transfer FSM. Head entry is visible
// combinationally so the FSM can decode and pop it in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pushReq,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popReq,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  // A full queue refuses pushes even when the head is leaving this cycle.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = pushReq && !full;
  assign doPop    = popReq && !empty;
  assign headData = mem[rdPtr];

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/bus_transfer_decoder.sv
// Drive side of the shared datapath bus: queues register-transfer commands and
// turns each into one registered source strobe and one registered load enable.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer on the bus; pops the queue head when one exists
// ST_DRIVE | strobes of one transfer are on the bus; pops the next head
// ST_WAIT  | MDR is driving the bus while memory read data is pending
module bus_transfer_decoder
  import bus_codes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CODE_W-1:0] cmd_src,
  input  logic [CODE_W-1:0] cmd_dst,
  input  logic              mem_ready,
  output logic [NSRC-1:0]   src_out,
  output logic [NDST-1:0]   dst_in,
  output logic              xfer_done,
  output logic              busy,
  output logic              err
);

  xferState_t        state;
  xferState_t        stateNext;
  xferCmd_t          headCmd;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              popReq;
  logic              headValid;
  logic [CODE_W-1:0] waitDst;
  logic [CODE_W-1:0] waitDstNext;
  logic [NSRC-1:0]   srcNext;
  logic [NDST-1:0]   dstNext;
  logic              doneNext;
  logic              errNext;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) cmdQueue (
    .clk      (clk),
    .clr      (clr),
    .pushReq  (cmd_valid),
    .pushData ({cmd_src, cmd_dst}),
    .popReq   (popReq),
    .headData (headCmd),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign cmd_ready = !fifoFull;
  assign busy      = !fifoEmpty || (state != ST_IDLE);
  assign headValid = srcValid(headCmd.src) && dstValid(headCmd.dst);

  // Next state and next strobe values; IDLE and DRIVE both consume the head so
  // queued transfers run back to back at one per cycle.
  always_comb begin
    stateNext   = state;
    popReq      = 1'b0;
    srcNext     = '0;
    dstNext     = '0;
    doneNext    = 1'b0;
    errNext     = err;
    waitDstNext = waitDst;
    case (state)
      ST_IDLE, ST_DRIVE: begin
        stateNext = ST_IDLE;
        if (!fifoEmpty) begin
          popReq = 1'b1;
          if (!headValid) begin
            errNext = 1'b1;
          end else if ((headCmd.src == SRC_MDR) && !mem_ready) begin
            stateNext   = ST_WAIT;
            srcNext     = decodeSrc(SRC_MDR);
            waitDstNext = headCmd.dst;
          end else begin
            stateNext = ST_DRIVE;
            srcNext   = decodeSrc(headCmd.src);
            dstNext   = decodeDst(headCmd.dst);
            doneNext  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        srcNext = decodeSrc(SRC_MDR);
        if (mem_ready) begin
          stateNext = ST_DRIVE;
          dstNext   = decodeDst(waitDst);
          doneNext  = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State, parked destination and all bus-facing outputs are registered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_IDLE;
      waitDst   <= '0;
      src_out   <= '0;
      dst_in    <= '0;
      xfer_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      waitDst   <= waitDstNext;
      src_out   <= srcNext;
      dst_in    <= dstNext;
      xfer_done <= doneNext;
      err       <= errNext;
    end
  end

endmodule

// File: tb/tb_bus_transfer_decoder.sv
// Bench for bus_transfer_decoder: fixed vector table, hand sequences for the
// multi-cycle cases and a randomized run against a queue-based reference model.
module tb_bus_transfer_decoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_src;
  logic [4:0]  cmd_dst;
  logic        mem_ready;
  logic [23:0] src_out;
  logic [23:0] dst_in;
  logic        xfer_done;
  logic        busy;
  logic        err;

  int checkCount = 0;
  int passCount  = 0;

  bus_transfer_decoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .mem_ready (mem_ready),
    .src_out   (src_out),
    .dst_in    (dst_in),
    .xfer_done (xfer_done),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", passCount, checkCount);
    $fatal(1, "watchdog");
  end

  // Reference model: a queue of pending commands plus an "MDR read pending" flag.
  bit [9:0]  mq[$];
  bit        mWait;
  bit [4:0]  mWaitDst;
  bit [23:0] eSrc;
  bit [23:0] eDst;
  bit        eDone;
  bit        eErr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mq.delete();
    mWait    = 1'b0;
    mWaitDst = '0;
    eSrc     = '0;
    eDst     = '0;
    eDone    = 1'b0;
    eErr     = 1'b0;
  endtask

  task automatic modelEdge();
    bit       acc;
    bit [9:0] c;
    bit [4:0] s;
    bit [4:0] d;
    acc   = cmd_valid && (mq.size() < DEPTH);
    eSrc  = '0;
    eDst  = '0;
    eDone = 1'b0;
    if (mWait) begin
      eSrc = 24'(1) << 21;
      if (mem_ready) begin
        eDst  = 24'(1) << mWaitDst;
        eDone = 1'b1;
        mWait = 1'b0;
      end
    end else if (mq.size() > 0) begin
      c = mq.pop_front();
      s = c[9:5];
      d = c[4:0];
      if (s > 5'd23 || d > 5'd23) begin
        eErr = 1'b1;
      end else if (s == 5'd21 && !mem_ready) begin
        mWait    = 1'b1;
        mWaitDst = d;
        eSrc     = 24'(1) << 21;
      end else begin
        eSrc  = 24'(1) << s;
        eDst  = 24'(1) << d;
        eDone = 1'b1;
      end
    end
    if (acc) mq.push_back({cmd_src, cmd_dst});
  endtask

  // One clock: model follows the edge, DUT is compared half a cycle later.
  task automatic tick();
    @(posedge clk);
    if (!clr) modelReset();
    else modelEdge();
    @(negedge clk);
    chk("mdl_src_out", src_out, eSrc);
    chk("mdl_dst_in", dst_in, eDst);
    chk("mdl_xfer_done", xfer_done, eDone);
    chk("mdl_err", err, eErr);
    chk("mdl_busy", busy, (mq.size() > 0) || mWait || eDone);
    chk("mdl_cmd_ready", cmd_ready, mq.size() < DEPTH);
  endtask

  task automatic offer(input logic [4:0] s, input logic [4:0] d);
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
  endtask

  typedef struct {
    logic [4:0]  src;
    logic [4:0]  dst;
    logic        memReady;
    logic [23:0] expSrc;
    logic [23:0] expDst;
    logic        expDone;
    logic        expErr;
  } vec_t;

  vec_t vecs[12];
  logic [4:0] seqSrc[5];
  logic [4:0] seqDst[5];

  initial begin
    vecs[0]  = '{5'd3,  5'd22, 1'b1, 24'h000008, 24'h400000, 1'b1, 1'b0};
    vecs[1]  = '{5'd0,  5'd0,  1'b0, 24'h000001, 24'h000001, 1'b1, 1'b0};
    vecs[2]  = '{5'd23, 5'd23, 1'b0, 24'h800000, 24'h800000, 1'b1, 1'b0};
    vecs[3]  = '{5'd16, 5'd17, 1'b1, 24'h010000, 24'h020000, 1'b1, 1'b0};
    vecs[4]  = '{5'd20, 5'd18, 1'b0, 24'h100000, 24'h040000, 1'b1, 1'b0};
    vecs[5]  = '{5'd21, 5'd19, 1'b1, 24'h200000, 24'h080000, 1'b1, 1'b0};
    vecs[6]  = '{5'd15, 5'd21, 1'b0, 24'h008000, 24'h200000, 1'b1, 1'b0};
    vecs[7]  = '{5'd27, 5'd5,  1'b1, 24'h000000, 24'h000000, 1'b0, 1'b1};
    vecs[8]  = '{5'd2,  5'd9,  1'b1, 24'h000004, 24'h000200, 1'b1, 1'b1};
    vecs[9]  = '{5'd2,  5'd30, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b1};
    vecs[10] = '{5'd24, 5'd24, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1};
    vecs[11] = '{5'd3,  5'd3,  1'b0, 24'h000008, 24'h000008, 1'b1, 1'b1};

    // Reset held with a command offered: nothing may be captured.
    modelReset();
    clr       = 1'b0;
    mem_ready = 1'b0;
    offer(5'd3, 5'd4);
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    cmd_valid = 1'b0;
    clr       = 1'b1;
    tick();
    chk("rst_nothing_queued", busy, 1'b0);

    // Single-command vectors: decode, invalid drop and sticky err.
    for (int i = 0; i < 12; i++) begin
      offer(vecs[i].src, vecs[i].dst);
      mem_ready = vecs[i].memReady;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("vec_src_out", src_out, vecs[i].expSrc);
      chk("vec_dst_in", dst_in, vecs[i].expDst);
      chk("vec_xfer_done", xfer_done, vecs[i].expDone);
      chk("vec_err", err, vecs[i].expErr);
      tick();
      chk("vec_after_idle", {src_out, dst_in, xfer_done, busy}, '0);
    end

    // Back-to-back commands with no gap: one transfer per cycle, in order.
    seqSrc = '{5'd3, 5'd16, 5'd21, 5'd7, 5'd23};
    seqDst = '{5'd22, 5'd0, 5'd19, 5'd4, 5'd18};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) offer(seqSrc[i], seqDst[i]);
      else cmd_valid = 1'b0;
      tick();
      if (i >= 1) begin
        chk("b2b_src", src_out, 24'(1) << seqSrc[i-1]);
        chk("b2b_dst", dst_in, 24'(1) << seqDst[i-1]);
        chk("b2b_done", xfer_done, 1'b1);
      end
    end
    tick();
    chk("b2b_idle_busy", busy, 1'b0);

    // Stall on MDR so the queue fills; a fifth offer is refused.
    seqSrc = '{5'd1, 5'd4, 5'd6, 5'd8, 5'd10};
    seqDst = '{5'd2, 5'd5, 5'd7, 5'd9, 5'd11};
    mem_ready = 1'b0;
    offer(5'd21, 5'd23);
    tick();
    for (int i = 0; i < 5; i++) begin
      offer(seqSrc[i], seqDst[i]);
      tick();
      if (i == 3) chk("full_ready_low", cmd_ready, 1'b0);
    end
    chk("full_wait_src", src_out, 24'h200000);
    chk("full_wait_dst", dst_in, 24'h000000);
    cmd_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("full_mdr_src", src_out, 24'h200000);
    chk("full_mdr_dst", dst_in, 24'h800000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_order_src", src_out, 24'(1) << seqSrc[i]);
      chk("full_order_dst", dst_in, 24'(1) << seqDst[i]);
      chk("full_order_done", xfer_done, 1'b1);
    end
    tick();
    chk("full_refused_not_run", {src_out, xfer_done, busy}, '0);

    // MDR waits exactly as long as memory is not ready.
    mem_ready = 1'b0;
    offer(5'd21, 5'd23);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_src_mdr_only", src_out, 24'h200000);
      chk("wait_no_dst", dst_in, 24'h000000);
      chk("wait_no_done", xfer_done, 1'b0);
    end
    mem_ready = 1'b1;
    tick();
    chk("wait_rel_src", src_out, 24'h200000);
    chk("wait_rel_dst", dst_in, 24'h800000);
    chk("wait_rel_done", xfer_done, 1'b1);
    tick();
    chk("wait_rel_idle", {src_out, dst_in, xfer_done}, '0);

    // Reset while waiting with commands queued behind.
    mem_ready = 1'b0;
    offer(5'd21, 5'd5);
    tick();
    offer(5'd1, 5'd2);
    tick();
    offer(5'd3, 5'd4);
    tick();
    cmd_valid = 1'b0;
    chk("midwait_src", src_out, 24'h200000);
    clr = 1'b0;
    modelReset();
    #1;
    chk("midwait_rst_src", src_out, 24'h000000);
    chk("midwait_rst_dst", dst_in, 24'h000000);
    chk("midwait_rst_err", err, 1'b0);
    chk("midwait_rst_busy", busy, 1'b0);
    chk("midwait_rst_ready", cmd_ready, 1'b1);
    tick();
    clr       = 1'b1;
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("midwait_fifo_empty", busy, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      cmd_valid = ($urandom_range(0, 99) < 60);
      r = int'($urandom_range(0, 19));
      if (r == 0) cmd_src = 5'($urandom_range(24, 31));
      else if (r < 6) cmd_src = 5'd21;
      else cmd_src = 5'($urandom_range(0, 23));
      if ($urandom_range(0, 19) == 0) cmd_dst = 5'($urandom_range(24, 31));
      else cmd_dst = 5'($urandom_range(0, 23));
      mem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (8) tick();
    chk("rand_drained", busy, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
